// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_port_arbiter_pkg;

    // Arbiter FSM: grant in IDLE, request phase in ADDR, response phase in DATA.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Which requester owns the single outstanding transaction.
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // Request fields captured at grant time and replayed to memory.
    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } hold_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// SRAM-like request/response bus shared by requesters and the memory port.
// Latency: n/a (signal bundle only).
// Backpressure: master holds req and fields until addr_ok; data_ok is a one-cycle pulse.
interface mem_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // Side that issues requests (a CPU requester, or the arbiter toward memory).
    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    // Side that accepts requests (the arbiter toward a requester, or the memory).
    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data-first with anti-starvation.
// Latency: addr_ok same cycle as grant in IDLE; mem_req from next cycle; data_ok passes mem_data_ok through.
// Backpressure: one outstanding transaction; losers wait in IDLE, ADDR stalls on mem_addr_ok, DATA on mem_data_ok.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  inst_bus,
    mem_port_arbiter_if.slave  data_bus,
    mem_port_arbiter_if.master mem_bus
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam bit               FAIRNESS = (STARVE_LIMIT != 0);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    hold_t            hold_q,  hold_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic inst_grant;
    logic data_grant;
    logic starved;
    logic done;

    // The fetch port never writes; its write fields exist only because the bus type is shared.
    logic unused_inst_fields;
    assign unused_inst_fields = ^{inst_bus.wr, inst_bus.wstrb, inst_bus.wdata};

    // Grant decision, field capture, starvation counting and FSM next state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        inst_grant = 1'b0;
        data_grant = 1'b0;
        starved    = FAIRNESS && inst_bus.req && (cnt_q == LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (data_bus.req && !starved) begin
                    data_grant = 1'b1;
                    owner_d    = OWN_DATA;
                    hold_d     = '{wr:    data_bus.wr,
                                   wstrb: data_bus.wstrb,
                                   addr:  data_bus.addr,
                                   wdata: data_bus.wdata};
                    // Count only grants that made a waiting fetch lose.
                    if (!inst_bus.req) begin
                        cnt_d = '0;
                    end else if (cnt_q != LIMIT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = ST_ADDR;
                end else if (inst_bus.req) begin
                    inst_grant = 1'b1;
                    owner_d    = OWN_INST;
                    hold_d     = '{wr:    1'b0,
                                   wstrb: 4'b0000,
                                   addr:  inst_bus.addr,
                                   wdata: 32'h0};
                    cnt_d      = '0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (mem_bus.addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_bus.data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner, hold and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_INST;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Completion is only honoured in DATA; stray mem_data_ok elsewhere is dropped.
    assign done = (state_q == ST_DATA) && mem_bus.data_ok;

    assign inst_bus.addr_ok = inst_grant;
    assign data_bus.addr_ok = data_grant;
    assign inst_bus.data_ok = done && (owner_q == OWN_INST);
    assign data_bus.data_ok = done && (owner_q == OWN_DATA);
    assign inst_bus.rdata   = mem_bus.rdata;
    assign data_bus.rdata   = mem_bus.rdata;

    assign mem_bus.req   = (state_q == ST_ADDR);
    assign mem_bus.wr    = hold_q.wr;
    assign mem_bus.wstrb = hold_q.wstrb;
    assign mem_bus.addr  = hold_q.addr;
    assign mem_bus.wdata = hold_q.wdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester and the data (MEM-stage) requester of the pipelined CPU. Requests are accepted one at a time and forwarded with a registered request/address/data handshake. Read data and completion are routed back to the requester that owns the transaction. Data accesses have priority, and a bounded anti-starvation counter guarantees instruction fetch forward progress.

## Interface
- STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending; 0 = strict data priority
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch request (read only)
- inst_addr  in  32  fetch byte address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte write enables, meaningful when data_wr=1
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  read data valid or write done this cycle
- data_rdata  out  32  data read data
- mem_req  out  1  request to memory
- mem_wr, mem_wstrb, mem_addr, mem_wdata  out  1/4/32/32  registered request fields
- mem_addr_ok  in  1  memory accepted the request
- mem_data_ok  in  1  memory completion
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, ADDR, DATA. There is one outstanding transaction at most.
- IDLE: the grant is decided combinationally.
  - Winner is data when data_req=1, unless inst_req=1 and starve_cnt==STARVE_LIMIT (with STARVE_LIMIT≠0). In that case the winner is inst.
  - If only one requester is active, it wins.
  - The winner's addr_ok is driven high in the same cycle.
  - The winner's fields and the owner bit are latched into hold registers. For an inst grant, wr=0 and wstrb=0.
  - Next state is ADDR.
- ADDR: mem_req=1 with the hold-register fields. When mem_addr_ok=1, go to DATA.
- DATA: mem_req=0. When mem_data_ok=1:
  - owner's data_ok = 1 and owner's rdata = mem_rdata, both combinational pass-through.
  - Go to IDLE.
- The non-owner's data_ok is always 0. rdata outputs equal mem_rdata and are qualified only by data_ok.
- starve_cnt:
  - On a data grant with inst_req=1: increment, saturating at STARVE_LIMIT.
  - On an inst grant: clear.
  - On a data grant with inst_req=0: clear.
- mem_data_ok in IDLE or ADDR is a protocol violation. It is ignored and produces no data_ok.
- Requesters hold req and their fields stable until addr_ok. The arbiter never re-samples the fields after the grant.

## Timing
- Reset values: state=IDLE, starve_cnt=0, hold registers=0. Consequently mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, and all addr_ok/data_ok=0.
- Request latency: grant at cycle T (addr_ok=1). mem_req is high from T+1 until the cycle with mem_addr_ok, inclusive.
- Minimum turnaround: mem_addr_ok at T+1 and mem_data_ok at T+2 give requester data_ok at T+2. The next grant is possible at T+3, i.e. in IDLE.
- Throughput: one transaction per 3 cycles at best. No back-to-back acceptance in DATA.
- Simultaneous requests in IDLE produce exactly one addr_ok. The loser waits in IDLE with req held.
- Reset mid-transaction (ADDR or DATA): return to IDLE next cycle and drop the transaction with no data_ok. The memory is reset by the same rst.

## Structure
- Shared package: FSM state encoding (IDLE/ADDR/DATA) and the owner encoding (OWN_INST=0, OWN_DATA=1).
- A single module is sufficient. The grant logic is small enough to stay inline.

## Test plan
- Lone fetch: inst_req with addr 0x1C000000; mem_addr_ok at T+1; mem_data_ok at T+2 with rdata 0x02800C0C. Expected: inst_addr_ok at T, inst_data_ok at T+2 with inst_rdata=0x02800C0C, data_data_ok=0.
- Data write: data_wr=1, wstrb=0b0100, addr 0x1C010002, wdata 0x00AB0000. Expected: mem_wr=1, mem_wstrb=0b0100 and mem_addr=0x1C010002 held through a 3-cycle mem_addr_ok stall; data_data_ok is returned on completion.
- Contention: inst_req and data_req both held continuously with STARVE_LIMIT=4. Expected grant order D,D,D,D,I,D,D,D,D,I.
- Strict priority: STARVE_LIMIT=0 with both requesters held for 10 transactions. Expected: all 10 grants go to data, and inst_addr_ok never asserts.
- Reset in DATA: rst asserted 1 cycle during a pending read, then mem_data_ok pulsed. Expected: outputs reset, FSM in IDLE, no data_ok.
- Stray mem_data_ok in IDLE with no requests. Expected: no inst_data_ok or data_data_ok, and the FSM stays in IDLE.
